ped_request: RTL and testbench
==============================

// Module: ped_request
// PURPOSE
//  Consumer side of the pedestrian push-button path. Takes the debounced button
//  level `buton` from the debouncer counter and turns each press into a held
//  request `req` to the intersection controller. Holds `req` until the
//  controller grants the pedestrian phase, then enforces a lockout after the
//  phase ends. Drives the "WAIT" indicator lamp at the crossing.
// PARAMETERS
//  LOCKOUT_CYC  16  clocks after `done` during which presses only set the deferred flag
//  BLINK_HALF   4   clocks per half-period of wait_lamp blink (on, then off)
//  CNT_W        5   width of lockout/blink counters; must hold max(LOCKOUT_CYC, BLINK_HALF)
// PORTS
//  clk        in   1  system clock, single domain
//  rst        in   1  synchronous reset, active-high
//  buton      in   1  debounced button level; 1 = pressed
//  grant      in   1  1-clk pulse from controller: pedestrian phase starts
//  done       in   1  1-clk pulse from controller: pedestrian phase ends
//  req        out  1  pedestrian request to controller, level
//  wait_lamp  out  1  WAIT indicator lamp drive
//  proto_err  out  1  1-clk pulse: grant/done arrived in an illegal state
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=IDLE, req=0, wait_lamp=0, proto_err=0,
//    deferred=0, counters=0, buton_q=1. buton_q=1 means a button held through
//    reset produces no request until it is released and pressed again.
//  - Press detect: rise = buton & ~buton_q; buton_q <= buton every clock.
//  - req and wait_lamp are registered decodes of the state and blink counter.
//    rise sampled at edge N -> req=1 after edge N (one-edge latency).
//  - IDLE: req=0, lamp=0.
//      rise -> PENDING.
//      grant or done -> proto_err pulse; stay IDLE.
//  - PENDING: req=1.
//      Lamp blinks: on entry, blink counter cleared and lamp=1 for BLINK_HALF
//      clocks, then 0 for BLINK_HALF clocks, repeating.
//      grant -> SERVING. Further rises are ignored.
//      done without grant -> proto_err; stay PENDING.
//  - SERVING: req=0, lamp=0.
//      done -> LOCKOUT and load the lockout counter with LOCKOUT_CYC-1.
//      rise is ignored. grant -> proto_err.
//  - LOCKOUT: req=0, lamp=1 steady while deferred=1, else lamp=0.
//      rise sets deferred. The counter decrements each clock.
//      At count 0: go to PENDING if deferred (or if rise occurs that same
//      cycle), otherwise go to IDLE; clear deferred. Lockout lasts exactly
//      LOCKOUT_CYC clocks.
//      grant or done -> proto_err.
//  - Simultaneous events:
//      IDLE, rise+grant -> PENDING plus proto_err.
//      PENDING, grant+done same cycle -> SERVING plus proto_err; done is dropped.
//      SERVING, done+rise -> LOCKOUT with deferred=0 (the press is dropped).
//  - Reset mid-operation wins over all inputs and returns everything to the
//    reset values on that edge.
//  - The lockout counter saturates at 0 and never wraps. The blink counter
//    wraps from 2*BLINK_HALF-1 to 0.
// STRUCTURE
//  - Shared header ped_defs.vh: 2-bit state codes S_IDLE=0, S_PENDING=1,
//    S_SERVING=2, S_LOCKOUT=3. The controller FSM includes it for the
//    grant/done contract.
//  - One sub-module: rise_detect (clk, rst, din, rise). Its register resets to 1.
//    The same block is reusable on other debounced inputs.
//  - Everything else in one always block for the FSM plus one for the counters.
// TESTING  (LOCKOUT_CYC=6, BLINK_HALF=2)
//  1. Press at cycle 10, grant at 20, done at 30:
//     -> req 1 from cycle 10 to 19, 0 from 20.
//     -> lamp 1,1,0,0,... from cycle 10.
//     -> state IDLE again after cycle 35.
//  2. Button held high across rst and beyond:
//     -> no req until release then re-press; req 1 after the re-press edge.
//  3. Press during LOCKOUT at cycle 32:
//     -> lamp steady 1 from cycle 32.
//     -> PENDING with req=1 immediately after lockout ends at cycle 35.
//  4. grant in IDLE, done in PENDING, grant in SERVING:
//     -> proto_err exactly 1 clock each; state unchanged.
//  5. rst asserted in PENDING and in LOCKOUT:
//     -> next cycle req=0, lamp=0, deferred=0, state IDLE.
//  6. rise and grant in the same IDLE cycle:
//     -> PENDING with req=1 plus one proto_err pulse.

Source files
------------

// File: rtl/ped_request_pkg.sv
// Shared definitions for the pedestrian request path: state codes and
// default timing. The state encoding is the one the intersection controller
// assumes for its grant/done contract, so the codes are pinned explicitly.
package ped_request_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_SERVING = 2'd2,
    S_LOCKOUT = 2'd3
  } ped_state_e;

  localparam int unsigned LOCKOUT_CYC_DEF = 16;
  localparam int unsigned BLINK_HALF_DEF  = 4;
  localparam int unsigned CNT_W_DEF       = 5;

  // True when a grant/done pulse is illegal in the given state.
  // PENDING only objects to done; SERVING only objects to grant.
  function automatic logic proto_violation(ped_state_e st, logic grant, logic done);
    logic bad;
    bad = 1'b0;
    case (st)
      S_IDLE:    bad = grant | done;
      S_PENDING: bad = done;
      S_SERVING: bad = grant;
      S_LOCKOUT: bad = grant | done;
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ped_request_if.sv
// Button/controller/lamp bundle for the pedestrian request block.
// slave = the request block, master = whoever drives button and controller pulses.
interface ped_request_if;

  logic buton;      // debounced button level, 1 = pressed
  logic grant;      // 1-clk pulse: pedestrian phase starts
  logic done;       // 1-clk pulse: pedestrian phase ends
  logic req;        // held request to the controller
  logic wait_lamp;  // WAIT indicator drive
  logic proto_err;  // 1-clk pulse on an illegal grant/done

  modport slave (
    input  buton,
    input  grant,
    input  done,
    output req,
    output wait_lamp,
    output proto_err
  );

  modport master (
    output buton,
    output grant,
    output done,
    input  req,
    input  wait_lamp,
    input  proto_err
  );

endinterface

// File: rtl/ped_request_rise_detect.sv
// Rising-edge detector for a debounced level. The history register resets
// to 1 so an input already high when reset releases is not seen as a press;
// it has to drop and come back first.
module ped_request_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Track the previous level; reset to "was high".
  always_ff @(posedge clk) begin
    if (rst) din_q <= 1'b1;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/ped_request.sv
// Pedestrian push-button request block. Converts button presses into a held
// request to the intersection controller, releases it on grant, enforces a
// lockout after the phase ends (remembering presses made during it), drives
// the WAIT lamp and flags grant/done pulses that arrive out of turn.
module ped_request
  import ped_request_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYC = LOCKOUT_CYC_DEF,
  parameter int unsigned BLINK_HALF  = BLINK_HALF_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  ped_request_if.slave  bus
);

  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_TOP = CNT_W'(2 * BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] BLINK_ON  = CNT_W'(BLINK_HALF);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             rise;
  ped_state_e       state_q, state_d;
  logic             deferred_q, deferred_d;
  logic             req_q, req_d;
  logic             lamp_q, lamp_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] lock_q, lock_d;
  logic [CNT_W-1:0] blink_q, blink_d;

  ped_request_rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.buton),
    .rise (rise)
  );

  // Next state, deferred-press flag and protocol error.
  always_comb begin
    state_d    = state_q;
    deferred_d = deferred_q;
    err_d      = proto_violation(state_q, bus.grant, bus.done);
    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_PENDING;
      end
      S_PENDING: begin
        // Grant wins; a done in the same cycle is only reported.
        if (bus.grant) state_d = S_SERVING;
      end
      S_SERVING: begin
        // A press here is dropped, even together with done.
        if (bus.done) state_d = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (lock_q == '0) begin
          state_d    = (deferred_q || rise) ? S_PENDING : S_IDLE;
          deferred_d = 1'b0;
        end else if (rise) begin
          deferred_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lockout countdown (saturating) and blink phase counter.
  always_comb begin
    lock_d  = lock_q;
    blink_d = '0;
    if (state_q == S_SERVING && bus.done) begin
      lock_d = LOCK_LOAD;
    end else if (state_q == S_LOCKOUT && lock_q != '0) begin
      lock_d = lock_q - CNT_ONE;
    end
    // Blink restarts from the "on" half on every entry into PENDING.
    if (state_q == S_PENDING && state_d == S_PENDING) begin
      blink_d = (blink_q == BLINK_TOP) ? '0 : blink_q + CNT_ONE;
    end
  end

  // Output decodes are taken from next state so they land with the state.
  always_comb begin
    req_d  = (state_d == S_PENDING);
    lamp_d = 1'b0;
    if (state_d == S_PENDING)      lamp_d = (blink_d < BLINK_ON);
    else if (state_d == S_LOCKOUT) lamp_d = deferred_d;
  end

  // FSM registers with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      deferred_q <= 1'b0;
      req_q      <= 1'b0;
      lamp_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      deferred_q <= deferred_d;
      req_q      <= req_d;
      lamp_q     <= lamp_d;
      err_q      <= err_d;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= '0;
      blink_q <= '0;
    end else begin
      lock_q  <= lock_d;
      blink_q <= blink_d;
    end
  end

  assign bus.req       = req_q;
  assign bus.wait_lamp = lamp_q;
  assign bus.proto_err = err_q;

endmodule

// File: tb/tb_ped_request.sv
// Directed bench for ped_request with LOCKOUT_CYC=6, BLINK_HALF=2.
// Inputs change 1ns after a rising edge; outputs are checked at that point,
// so each check sees the result of the edge just taken.
module tb_ped_request;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  ped_request_if bus ();

  ped_request #(
    .LOCKOUT_CYC (6),
    .BLINK_HALF  (2),
    .CNT_W       (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic outs(input string tag, input logic r, input logic l, input logic e);
    chk({tag, "_req"},  bus.req,       r);
    chk({tag, "_lamp"}, bus.wait_lamp, l);
    chk({tag, "_err"},  bus.proto_err, e);
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst = 1'b1; bus.buton = 1'b0; bus.grant = 1'b0; bus.done = 1'b0;
    tick(2);
    outs("reset", 0, 0, 0);
    rst = 1'b0;
    tick(1);
    outs("idle", 0, 0, 0);

    // press -> request, blink 1,1,0,0,1 ; grant clears ; lockout 6 clocks
    bus.buton = 1'b1; tick(1); outs("t1_press", 1, 1, 0);
    bus.buton = 1'b0; tick(1); chk("t1_blink1", bus.wait_lamp, 1);
    tick(1); chk("t1_blink2", bus.wait_lamp, 0);
    tick(1); chk("t1_blink3", bus.wait_lamp, 0);
    tick(1); outs("t1_blink4", 1, 1, 0);
    bus.grant = 1'b1; tick(1); bus.grant = 1'b0; outs("t1_grant", 0, 0, 0);
    tick(3); chk("t1_serving", bus.req, 0);
    bus.done = 1'b1; tick(1); bus.done = 1'b0; outs("t1_done", 0, 0, 0);
    tick(5); chk("t1_lock_last", bus.req, 0);
    tick(1); outs("t1_idle_again", 0, 0, 0);
    bus.buton = 1'b1; tick(1); bus.buton = 1'b0; chk("t1_repress", bus.req, 1);

    // press in lockout -> steady lamp, pending right at lockout end
    bus.grant = 1'b1; tick(1); bus.grant = 1'b0;
    bus.done = 1'b1; tick(1); bus.done = 1'b0;
    tick(1);
    bus.buton = 1'b1; tick(1); bus.buton = 1'b0; outs("t3_defer", 0, 1, 0);
    tick(3); outs("t3_lock_last", 0, 1, 0);
    tick(1); outs("t3_exit_pend", 1, 1, 0);

    // press on the final lockout cycle still goes to pending
    bus.grant = 1'b1; tick(1); bus.grant = 1'b0;
    bus.done = 1'b1; tick(1); bus.done = 1'b0;
    tick(5); outs("t3b_lock_last", 0, 0, 0);
    bus.buton = 1'b1; tick(1); bus.buton = 1'b0; outs("t3b_zero_rise", 1, 1, 0);

    // reset during lockout with a deferred press
    bus.grant = 1'b1; tick(1); bus.grant = 1'b0;
    bus.done = 1'b1; tick(1); bus.done = 1'b0;
    bus.buton = 1'b1; tick(1); bus.buton = 1'b0; chk("t5_defer_lamp", bus.wait_lamp, 1);
    rst = 1'b1; tick(1); rst = 1'b0; outs("t5_rst_lock", 0, 0, 0);
    tick(6); outs("t5_no_pend", 0, 0, 0);

    // button held across reset needs release and re-press
    bus.buton = 1'b1; rst = 1'b1; tick(1); rst = 1'b0;
    tick(3); chk("t2_held", bus.req, 0);
    bus.buton = 1'b0; tick(1); chk("t2_release", bus.req, 0);
    bus.buton = 1'b1; tick(1); outs("t2_repress", 1, 1, 0);
    // reset during pending
    rst = 1'b1; tick(1); rst = 1'b0; outs("t5_rst_pend", 0, 0, 0);
    bus.buton = 1'b0; tick(1); chk("t5_idle", bus.req, 0);

    // illegal pulses: one-clock error, state unchanged
    bus.grant = 1'b1; tick(1); bus.grant = 1'b0; outs("t4_idle_grant", 0, 0, 1);
    tick(1); outs("t4_idle_grant_end", 0, 0, 0);
    bus.done = 1'b1; tick(1); bus.done = 1'b0; outs("t4_idle_done", 0, 0, 1);
    tick(1);
    bus.buton = 1'b1; tick(1); bus.buton = 1'b0; chk("t4_pend", bus.req, 1);
    bus.done = 1'b1; tick(1); bus.done = 1'b0; outs("t4_pend_done", 1, 1, 1);
    tick(1); chk("t4_pend_done_end", bus.proto_err, 0); chk("t4_still_pend", bus.req, 1);
    bus.grant = 1'b1; tick(1); bus.grant = 1'b0; outs("t4_grant_ok", 0, 0, 0);
    bus.grant = 1'b1; tick(1); bus.grant = 1'b0; outs("t4_serv_grant", 0, 0, 1);
    tick(1); chk("t4_serv_grant_end", bus.proto_err, 0);
    bus.done = 1'b1; tick(1); bus.done = 1'b0; outs("t4_done_ok", 0, 0, 0);
    bus.grant = 1'b1; tick(1); bus.grant = 1'b0; outs("t4_lock_grant", 0, 0, 1);
    bus.done = 1'b1; tick(1); bus.done = 1'b0; outs("t4_lock_done", 0, 0, 1);
    tick(4); outs("t4_lock_over", 0, 0, 0);

    // rise and grant together in idle
    bus.buton = 1'b1; bus.grant = 1'b1; tick(1);
    bus.buton = 1'b0; bus.grant = 1'b0; outs("t6_rise_grant", 1, 1, 1);
    tick(1); outs("t6_after", 1, 1, 0);

    // grant+done together in pending: serving, done dropped
    bus.grant = 1'b1; bus.done = 1'b1; tick(1);
    bus.grant = 1'b0; bus.done = 1'b0; outs("sim_gd", 0, 0, 1);
    bus.buton = 1'b1; tick(1); bus.buton = 1'b0; outs("sim_serv_press", 0, 0, 0);
    tick(1);
    // done+rise in serving: lockout without deferred press
    bus.buton = 1'b1; bus.done = 1'b1; tick(1);
    bus.buton = 1'b0; bus.done = 1'b0; outs("sim_done_rise", 0, 0, 0);
    tick(6); outs("sim_idle_end", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
